pipe_stall_sequencer: RTL and testbench

//  Central stall/flush sequencer for the VLIW pipeline front end.

---
 rtl/vliw_pipe_pkg.sv | 13 +
 rtl/pipe_stall_sequencer_if.sv | 37 +++
 rtl/load_use_detect.sv | 26 ++
 rtl/pipe_stall_sequencer.sv | 100 ++++++++++
 tb/tb_pipe_stall_sequencer.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/vliw_pipe_pkg.sv
// Shared types and defaults for the VLIW front-end pipeline control blocks.
package vliw_pipe_pkg;

  localparam int REG_W_DEFAULT = 3;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    BR_FLUSH   = 2'd2,
    MC_BUSY    = 2'd3
  } seq_state_t;

endpackage

// File: rtl/pipe_stall_sequencer_if.sv
// Hazard inputs and pipeline-register controls exchanged between the
// front end (master) and the stall sequencer (slave).
interface pipe_stall_sequencer_if #(
  parameter int REG_W    = vliw_pipe_pkg::REG_W_DEFAULT,
  parameter int MC_CNT_W = 4,
  parameter int PERF_W   = 16
);
  logic                id_ex_mem_read;
  logic [REG_W-1:0]    id_ex_sd;
  logic [REG_W-1:0]    if_id_rm;
  logic [REG_W-1:0]    if_id_rd;
  logic [REG_W-1:0]    if_id_sm;
  logic [REG_W-1:0]    if_id_sn;
  logic                branch_taken;
  logic                mc_start;
  logic [MC_CNT_W-1:0] mc_cycles;
  logic                pc_write;
  logic                if_id_write;
  logic                id_ex_write;
  logic                id_ex_bubble;
  logic                if_id_flush;
  logic [PERF_W-1:0]   stall_cycles;

  modport master (
    output id_ex_mem_read, id_ex_sd, if_id_rm, if_id_rd, if_id_sm, if_id_sn,
           branch_taken, mc_start, mc_cycles,
    input  pc_write, if_id_write, id_ex_write, id_ex_bubble, if_id_flush,
           stall_cycles
  );

  modport slave (
    input  id_ex_mem_read, id_ex_sd, if_id_rm, if_id_rd, if_id_sm, if_id_sn,
           branch_taken, mc_start, mc_cycles,
    output pc_write, if_id_write, id_ex_write, id_ex_bubble, if_id_flush,
           stall_cycles
  );
endinterface

// File: rtl/load_use_detect.sv
// Flags a load in ID/EX whose destination feeds any source of the IF/ID instruction.
module load_use_detect #(
  parameter int REG_W = vliw_pipe_pkg::REG_W_DEFAULT
) (
  input  logic             mem_read,
  input  logic [REG_W-1:0] sd,
  input  logic [REG_W-1:0] rm,
  input  logic [REG_W-1:0] rd,
  input  logic [REG_W-1:0] sm,
  input  logic [REG_W-1:0] sn,
  output logic             load_use
);
  logic [REG_W-1:0] srcs [4];
  logic [3:0]       hit;

  assign srcs[0] = rm;
  assign srcs[1] = rd;
  assign srcs[2] = sm;
  assign srcs[3] = sn;

  for (genvar gi = 0; gi < 4; gi++) begin : g_cmp
    assign hit[gi] = (srcs[gi] == sd);
  end

  assign load_use = mem_read & (|hit);
endmodule

// File: rtl/pipe_stall_sequencer.sv
// Stall/flush sequencer: merges load-use, taken-branch and multi-cycle EX
// hazards into PC / IF/ID / ID/EX enables, bubble and flush controls.
module pipe_stall_sequencer
  import vliw_pipe_pkg::*;
#(
  parameter int REG_W      = REG_W_DEFAULT,
  parameter int BR_PENALTY = 2,
  parameter int MC_CNT_W   = 4,
  parameter int PERF_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipe_stall_sequencer_if.slave sif
);
  // Counter must hold both the longest EX latency and the branch penalty.
  localparam int BR_W  = $clog2(BR_PENALTY + 1);
  localparam int CNT_W = (MC_CNT_W > BR_W) ? MC_CNT_W : BR_W;

  seq_state_t        state_reg, state_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [PERF_W-1:0] stall_cycles_reg;
  logic              load_use;
  logic              pc_write, if_id_write, id_ex_write, id_ex_bubble, if_id_flush;

  load_use_detect #(.REG_W(REG_W)) u_load_use_detect (
    .mem_read (sif.id_ex_mem_read),
    .sd       (sif.id_ex_sd),
    .rm       (sif.if_id_rm),
    .rd       (sif.if_id_rd),
    .sm       (sif.if_id_sm),
    .sn       (sif.if_id_sn),
    .load_use (load_use)
  );

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    case (state_reg)
      RUN, LOAD_STALL: begin
        state_next = RUN;
        if (sif.branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          if (BR_PENALTY > 1) begin
            state_next = BR_FLUSH;
            count_next = CNT_W'(BR_PENALTY - 1);
          end
        end else if (sif.mc_start && (sif.mc_cycles >= MC_CNT_W'(2))) begin
          state_next = MC_BUSY;
          count_next = CNT_W'(sif.mc_cycles - MC_CNT_W'(1));
        end else if (load_use && (state_reg == RUN)) begin
          // ID/EX already holds a bubble in LOAD_STALL, so the hazard is resolved.
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          state_next   = LOAD_STALL;
        end
      end
      BR_FLUSH: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        count_next   = count_reg - CNT_W'(1);
        if (count_reg == CNT_W'(1)) state_next = RUN;
      end
      MC_BUSY: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_write = 1'b0;
        count_next  = count_reg - CNT_W'(1);
        if (count_reg == CNT_W'(1)) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= RUN;
      count_reg        <= '0;
      stall_cycles_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      if (!pc_write && (stall_cycles_reg != {PERF_W{1'b1}}))
        stall_cycles_reg <= stall_cycles_reg + PERF_W'(1);
    end
  end

  assign sif.pc_write     = pc_write;
  assign sif.if_id_write  = if_id_write;
  assign sif.id_ex_write  = id_ex_write;
  assign sif.id_ex_bubble = id_ex_bubble;
  assign sif.if_id_flush  = if_id_flush;
  assign sif.stall_cycles = stall_cycles_reg;
endmodule

// File: tb/tb_pipe_stall_sequencer.sv
// Directed bench for pipe_stall_sequencer; a second instance with a 2-bit
// stall counter shares the stimulus to exercise saturation.
module tb_pipe_stall_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pipe_stall_sequencer_if #(.REG_W(3), .MC_CNT_W(4), .PERF_W(16)) if1 ();
  pipe_stall_sequencer_if #(.REG_W(3), .MC_CNT_W(4), .PERF_W(2))  if2 ();

  assign if2.id_ex_mem_read = if1.id_ex_mem_read;
  assign if2.id_ex_sd       = if1.id_ex_sd;
  assign if2.if_id_rm       = if1.if_id_rm;
  assign if2.if_id_rd       = if1.if_id_rd;
  assign if2.if_id_sm       = if1.if_id_sm;
  assign if2.if_id_sn       = if1.if_id_sn;
  assign if2.branch_taken   = if1.branch_taken;
  assign if2.mc_start       = if1.mc_start;
  assign if2.mc_cycles      = if1.mc_cycles;

  pipe_stall_sequencer #(.REG_W(3), .BR_PENALTY(2), .MC_CNT_W(4), .PERF_W(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (if1.slave)
  );

  pipe_stall_sequencer #(.REG_W(3), .BR_PENALTY(2), .MC_CNT_W(4), .PERF_W(2)) u_dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (if2.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks the five control outputs of the main instance in one go.
  task automatic chk_ctl(input string tag, input logic pcw, input logic ifw,
                         input logic idw, input logic bub, input logic fl);
    chk({tag, ".pc_write"},     32'(if1.pc_write),     32'(pcw));
    chk({tag, ".if_id_write"},  32'(if1.if_id_write),  32'(ifw));
    chk({tag, ".id_ex_write"},  32'(if1.id_ex_write),  32'(idw));
    chk({tag, ".id_ex_bubble"}, 32'(if1.id_ex_bubble), 32'(bub));
    chk({tag, ".if_id_flush"},  32'(if1.if_id_flush),  32'(fl));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    if1.id_ex_mem_read = 1'b0;
    if1.id_ex_sd       = 3'd3;
    if1.if_id_rm       = 3'd0;
    if1.if_id_rd       = 3'd1;
    if1.if_id_sm       = 3'd2;
    if1.if_id_sn       = 3'd4;
    if1.branch_taken   = 1'b0;
    if1.mc_start       = 1'b0;
    if1.mc_cycles      = 4'd0;

    // 1: reset and idle
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    #1;
    chk_ctl("t1_idle", 1, 1, 1, 0, 0);
    chk("t1_stall_cycles", 32'(if1.stall_cycles), 32'd0);
    $display("t1 reset/idle done");

    // 2: load-use on sn, inputs held for two cycles
    if1.id_ex_mem_read = 1'b1;
    if1.if_id_sn       = 3'd3;
    #1;
    chk_ctl("t2_stall", 0, 0, 1, 1, 0);
    tick();
    #1;
    chk_ctl("t2_after", 1, 1, 1, 0, 0);
    chk("t2_stall_cycles", 32'(if1.stall_cycles), 32'd1);
    if1.id_ex_mem_read = 1'b0;
    tick();
    $display("t2 load-use stall done");

    // 3: branch beats a simultaneous load-use; two flush cycles, no stall
    if1.id_ex_mem_read = 1'b1;
    if1.branch_taken   = 1'b1;
    #1;
    chk_ctl("t3_br0", 1, 1, 1, 1, 1);
    tick();
    if1.branch_taken   = 1'b0;
    if1.id_ex_mem_read = 1'b0;
    #1;
    chk_ctl("t3_br1", 1, 1, 1, 1, 1);
    tick();
    #1;
    chk_ctl("t3_run", 1, 1, 1, 0, 0);
    chk("t3_stall_cycles", 32'(if1.stall_cycles), 32'd1);
    $display("t3 branch flush done");

    // 4: four-cycle EX op
    if1.mc_start  = 1'b1;
    if1.mc_cycles = 4'd4;
    #1;
    chk_ctl("t4_issue", 1, 1, 1, 0, 0);
    tick();
    if1.mc_start = 1'b0;
    #1;
    chk_ctl("t4_busy1", 0, 0, 0, 0, 0);
    tick();
    #1;
    chk_ctl("t4_busy2", 0, 0, 0, 0, 0);
    tick();
    #1;
    chk_ctl("t4_busy3", 0, 0, 0, 0, 0);
    chk("t4_stall_mid", 32'(if1.stall_cycles), 32'd3);
    tick();
    #1;
    chk_ctl("t4_run", 1, 1, 1, 0, 0);
    chk("t4_stall_cycles", 32'(if1.stall_cycles), 32'd4);
    $display("t4 multi-cycle op done");

    // 5: latency 1 and 0 are single-cycle
    if1.mc_start  = 1'b1;
    if1.mc_cycles = 4'd1;
    #1;
    chk_ctl("t5_lat1", 1, 1, 1, 0, 0);
    tick();
    if1.mc_cycles = 4'd0;
    #1;
    chk_ctl("t5_lat0", 1, 1, 1, 0, 0);
    tick();
    if1.mc_start = 1'b0;
    #1;
    chk_ctl("t5_after", 1, 1, 1, 0, 0);
    chk("t5_stall_cycles", 32'(if1.stall_cycles), 32'd4);
    chk("t5_sat_stall", 32'(if2.stall_cycles), 32'd3);
    $display("t5 short ops done");

    // 6: async reset in the second MC_BUSY cycle
    if1.mc_start  = 1'b1;
    if1.mc_cycles = 4'd4;
    tick();
    if1.mc_start = 1'b0;
    tick();
    #1;
    chk_ctl("t6_busy2", 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk_ctl("t6_reset", 1, 1, 1, 0, 0);
    chk("t6_stall_reset", 32'(if1.stall_cycles), 32'd0);
    chk("t6_sat_reset", 32'(if2.stall_cycles), 32'd0);
    #1 rst_n = 1'b1;
    tick();
    #1;
    chk_ctl("t6_run", 1, 1, 1, 0, 0);
    $display("t6 async reset done");

    // 7: five stall cycles saturate the 2-bit counter at 3
    if1.mc_start  = 1'b1;
    if1.mc_cycles = 4'd6;
    tick();
    if1.mc_start = 1'b0;
    repeat (4) tick();
    #1;
    chk_ctl("t7_busy5", 0, 0, 0, 0, 0);
    tick();
    #1;
    chk_ctl("t7_run", 1, 1, 1, 0, 0);
    chk("t7_stall_cycles", 32'(if1.stall_cycles), 32'd5);
    chk("t7_sat_stall", 32'(if2.stall_cycles), 32'd3);
    $display("t7 saturation done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
